// File: rtl/mc14500b_pkg.sv
// Shared MC14500B definitions: opcode values, sequencer states and redirect selection.
package mc14500b_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_JMP  = 3'd1,
    RD_RTN  = 3'd2,
    RD_FLGO = 3'd3,
    RD_FLGF = 3'd4
  } redir_e;

  // Strobes only count against a valid word; jmp > rtn > flgo > flgf.
  function automatic redir_e sel_redirect(
    input logic valid,
    input logic jmp,
    input logic rtn,
    input logic flgo,
    input logic flgf
  );
    redir_e r;
    r = RD_NONE;
    if (valid) begin
      if (jmp)       r = RD_JMP;
      else if (rtn)  r = RD_RTN;
      else if (flgo) r = RD_FLGO;
      else if (flgf) r = RD_FLGF;
    end
    return r;
  endfunction

endpackage

// File: rtl/mc14500b_stack.sv
// Return-address stack for JMP/RTN; pushes onto a full stack are dropped, pops of an empty one read zero.
module mc14500b_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];

  assign o_full      = (sp_q == SP_W'(DEPTH));
  assign o_empty     = (sp_q == '0);
  assign o_overflow  = i_push & o_full;
  assign o_underflow = i_pop & o_empty;

  always_comb begin
    sp_d   = sp_q;
    mem_d  = mem_q;
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) o_data = mem_q[i];
    end
    if (i_push && !o_full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SP_W'(i)) mem_d[i] = i_data;
      end
      sp_d = sp_q + SP_W'(1);
    end else if (i_pop && !o_empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mc14500b_seq.sv
// MC14500B program sequencer: PC, one-deep fetch pipeline with valid flag, redirects and return stack.
module mc14500b_seq
  import mc14500b_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [ADDR_W+3:0] i_rom_data,
  output logic [3:0]        o_op,
  output logic [ADDR_W-1:0] o_ioaddr,
  input  logic              i_jmp,
  input  logic              i_rtn,
  input  logic              i_flgf,
  input  logic              i_flgo,
  output logic              o_running,
  output logic              o_scan,
  output logic              o_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              v_q, v_d;
  logic              err_q, err_d;
  logic              scan_q, scan_d;

  logic [3:0]        word_op;
  logic [ADDR_W-1:0] word_addr;
  redir_e            redir;
  logic              skz_hold;
  logic              stop;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_data;
  logic              stk_full, stk_empty, stk_ovf, stk_unf;

  assign word_op   = i_rom_data[3:0];
  assign word_addr = i_rom_data[ADDR_W+3:4];

  assign redir = sel_redirect(v_q, i_jmp, i_rtn, i_flgo, i_flgf);
  assign push  = (redir == RD_JMP);
  assign pop   = (redir == RD_RTN);

  // A stop request is held off while SKZ executes so the skip slot still gets a real word.
  assign skz_hold = v_q && (word_op == OP_SKZ);
  assign stop     = (state_q == ST_RUN) &&
                    ((!i_run && !skz_hold) || (redir == RD_FLGF));

  mc14500b_stack #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (push),
    .i_pop      (pop),
    .i_data     (pc_q),
    .o_data     (stk_data),
    .o_full     (stk_full),
    .o_empty    (stk_empty),
    .o_overflow (stk_ovf),
    .o_underflow(stk_unf)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    v_d     = 1'b0;
    scan_d  = 1'b0;
    err_d   = err_q | stk_ovf | stk_unf;

    case (state_q)
      ST_STOP: begin
        if (i_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        case (redir)
          RD_JMP:  pc_d = word_addr;
          RD_RTN:  pc_d = stk_empty ? '0 : stk_data;
          RD_FLGO: begin
            pc_d   = '0;
            scan_d = 1'b1;
          end
          RD_FLGF: pc_d = pc_q;
          default: pc_d = stop ? pc_q : pc_q + ADDR_W'(1);
        endcase
        if (stop) state_d = ST_STOP;
        // The word fetched this cycle is only kept when nothing redirects or stops.
        v_d = !stop && (redir == RD_NONE);
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_STOP;
      pc_q    <= '0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
      scan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      v_q     <= v_d;
      err_q   <= err_d;
      scan_q  <= scan_d;
    end
  end

  assign o_rom_addr = pc_q;
  assign o_op       = v_q ? word_op : OP_NOPO;
  assign o_ioaddr   = v_q ? word_addr : '0;
  assign o_running  = (state_q == ST_RUN);
  assign o_scan     = scan_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_mc14500b_seq.sv
// Scoreboard bench for mc14500b_seq: a ROM and a small ICU decoder wrap the DUT; per-cycle expectations are queued.
module tb_mc14500b_seq;
  import mc14500b_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] rom_addr, ioaddr;
  logic [AW+3:0] rom_data;
  logic [3:0]    op;
  logic          jmp, rtn, flgf, flgo;
  logic          running, scan, err;
  logic          skip_q;
  logic          rr = 1'b0;
  logic [AW+3:0] rom [256];

  always #5 clk = ~clk;

  mc14500b_seq #(.ADDR_W(AW), .DEPTH(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_run     (run),
    .o_rom_addr(rom_addr),
    .i_rom_data(rom_data),
    .o_op      (op),
    .o_ioaddr  (ioaddr),
    .i_jmp     (jmp),
    .i_rtn     (rtn),
    .i_flgf    (flgf),
    .i_flgo    (flgo),
    .o_running (running),
    .o_scan    (scan),
    .o_err     (err)
  );

  // Synchronous program ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ICU model: decodes o_op directly (bubbles decode as NOPO), SKZ with RR=0 suppresses the next word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_q <= 1'b0;
    else        skip_q <= (op == OP_SKZ) && !rr;
  end
  assign jmp  = (op == OP_JMP)  && !skip_q;
  assign rtn  = (op == OP_RTN)  && !skip_q;
  assign flgo = (op == OP_NOPO) && !skip_q;
  assign flgf = (op == OP_NOPF) && !skip_q;

  typedef struct {
    string      nm;
    logic [3:0] op;
    logic [7:0] io;
    logic [7:0] addr;
    logic       run;
    logic       scan;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({op, ioaddr, rom_addr, running, scan, err} ===
            {e.op, e.io, e.addr, e.run, e.scan, e.err}) begin
          passed++;
        end else begin
          $display("FAIL %s: got op=%h io=%h addr=%h run=%b scan=%b err=%b, expected op=%h io=%h addr=%h run=%b scan=%b err=%b",
                   e.nm, op, ioaddr, rom_addr, running, scan, err,
                   e.op, e.io, e.addr, e.run, e.scan, e.err);
        end
        $display("check %s: op=%h io=%h addr=%h run=%b scan=%b err=%b",
                 e.nm, op, ioaddr, rom_addr, running, scan, err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [3:0] o, input logic [7:0] io,
                          input logic [7:0] addr, input logic r, input logic s, input logic e);
    exp_t x;
    x.nm = nm; x.op = o; x.io = io; x.addr = addr; x.run = r; x.scan = s; x.err = e;
    sb.push_back(x);
  endtask

  function automatic logic [11:0] w(input logic [7:0] a, input logic [3:0] o);
    return {a, o};
  endfunction

  task automatic hold_reset();
    tick();
    run   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = w(8'h00, OP_LD);
  endtask

  task automatic release_reset(input string nm);
    tick();
    rst_n = 1'b1;
    run   = 1'b1;
    push_exp({nm, " reset"}, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    hold_reset();
    tick();

    // Straight-line program ending in NOPO: scan pulse and wrap to 0.
    hold_reset();
    rom[0] = w(8'h01, OP_LD); rom[1] = w(8'h02, OP_AND);
    rom[2] = w(8'h03, OP_STO); rom[3] = w(8'h00, OP_NOPO);
    release_reset("A");
    tick(); push_exp("A bubble", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); push_exp("A LD",     4'h1, 8'h01, 8'h01, 1, 0, 0);
    tick(); push_exp("A AND",    4'h3, 8'h02, 8'h02, 1, 0, 0);
    tick(); push_exp("A STO",    4'h8, 8'h03, 8'h03, 1, 0, 0);
    tick(); push_exp("A NOPO",   4'h0, 8'h00, 8'h04, 1, 0, 0);
    tick(); push_exp("A scan",   4'h0, 8'h00, 8'h00, 1, 1, 0);
    tick(); push_exp("A LD2",    4'h1, 8'h01, 8'h01, 1, 0, 0);

    // JMP at 0x05 to 0x40, RTN at 0x41 back to 0x06.
    hold_reset();
    rom[5] = w(8'h40, OP_JMP); rom[8'h40] = w(8'h55, OP_LD);
    rom[8'h41] = w(8'h00, OP_RTN); rom[6] = w(8'h66, OP_STO);
    release_reset("B");
    tick(); push_exp("B bubble0", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); push_exp("B LD", 4'h1, 8'h00, 8'(i + 1), 1, 0, 0);
    end
    tick(); push_exp("B JMP",    4'hC, 8'h40, 8'h06, 1, 0, 0);
    tick(); push_exp("B bubble", 4'h0, 8'h00, 8'h40, 1, 0, 0);
    tick(); push_exp("B tgt",    4'h1, 8'h55, 8'h41, 1, 0, 0);
    tick(); push_exp("B RTN",    4'hD, 8'h00, 8'h42, 1, 0, 0);
    tick(); push_exp("B bubble", 4'h0, 8'h00, 8'h06, 1, 0, 0);
    tick(); push_exp("B resume", 4'h8, 8'h66, 8'h07, 1, 0, 0);

    // Five nested JMPs overflow a 4-deep stack; unwinding then pops empty.
    hold_reset();
    rom[0] = w(8'h10, OP_JMP); rom[8'h10] = w(8'h20, OP_JMP);
    rom[8'h20] = w(8'h30, OP_JMP); rom[8'h30] = w(8'h40, OP_JMP);
    rom[8'h40] = w(8'h50, OP_JMP); rom[8'h50] = w(8'h00, OP_RTN);
    rom[8'h31] = w(8'h00, OP_RTN); rom[8'h21] = w(8'h00, OP_RTN);
    rom[8'h11] = w(8'h00, OP_RTN); rom[8'h01] = w(8'h00, OP_RTN);
    release_reset("C");
    tick(); push_exp("C bubble", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); push_exp("C JMP1",   4'hC, 8'h10, 8'h01, 1, 0, 0);
    tick(); push_exp("C bub1",   4'h0, 8'h00, 8'h10, 1, 0, 0);
    tick(); push_exp("C JMP2",   4'hC, 8'h20, 8'h11, 1, 0, 0);
    tick(); push_exp("C bub2",   4'h0, 8'h00, 8'h20, 1, 0, 0);
    tick(); push_exp("C JMP3",   4'hC, 8'h30, 8'h21, 1, 0, 0);
    tick(); push_exp("C bub3",   4'h0, 8'h00, 8'h30, 1, 0, 0);
    tick(); push_exp("C JMP4",   4'hC, 8'h40, 8'h31, 1, 0, 0);
    tick(); push_exp("C bub4",   4'h0, 8'h00, 8'h40, 1, 0, 0);
    tick(); push_exp("C JMP5",   4'hC, 8'h50, 8'h41, 1, 0, 0);
    tick(); push_exp("C ovf",    4'h0, 8'h00, 8'h50, 1, 0, 1);
    tick(); push_exp("C RTN1",   4'hD, 8'h00, 8'h51, 1, 0, 1);
    tick(); push_exp("C pop1",   4'h0, 8'h00, 8'h31, 1, 0, 1);
    tick(); push_exp("C RTN2",   4'hD, 8'h00, 8'h32, 1, 0, 1);
    tick(); push_exp("C pop2",   4'h0, 8'h00, 8'h21, 1, 0, 1);
    tick(); push_exp("C RTN3",   4'hD, 8'h00, 8'h22, 1, 0, 1);
    tick(); push_exp("C pop3",   4'h0, 8'h00, 8'h11, 1, 0, 1);
    tick(); push_exp("C RTN4",   4'hD, 8'h00, 8'h12, 1, 0, 1);
    tick(); push_exp("C pop4",   4'h0, 8'h00, 8'h01, 1, 0, 1);
    tick(); push_exp("C RTN5",   4'hD, 8'h00, 8'h02, 1, 0, 1);
    tick(); push_exp("C empty",  4'h0, 8'h00, 8'h00, 1, 0, 1);
    tick(); push_exp("C again",  4'hC, 8'h10, 8'h01, 1, 0, 1);

    // NOPF at 0x10 stops with PC held at 0x11; re-run resumes there.
    hold_reset();
    rom[0] = w(8'h10, OP_JMP); rom[8'h10] = w(8'h00, OP_NOPF);
    rom[8'h11] = w(8'h77, OP_STO);
    release_reset("D");
    tick(); push_exp("D bubble", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); push_exp("D JMP",    4'hC, 8'h10, 8'h01, 1, 0, 0);
    tick(); push_exp("D bub",    4'h0, 8'h00, 8'h10, 1, 0, 0);
    tick(); push_exp("D NOPF",   4'hF, 8'h00, 8'h11, 1, 0, 0);
    tick(); run = 1'b0; push_exp("D stop",  4'h0, 8'h00, 8'h11, 0, 0, 0);
    tick(); push_exp("D held",   4'h0, 8'h00, 8'h11, 0, 0, 0);
    tick(); run = 1'b1; push_exp("D rerun", 4'h0, 8'h00, 8'h11, 0, 0, 0);
    tick(); push_exp("D bub2",   4'h0, 8'h00, 8'h11, 1, 0, 0);
    tick(); push_exp("D resume", 4'h8, 8'h77, 8'h12, 1, 0, 0);

    // SKZ with RR=0 then JMP; run dropped on the SKZ cycle takes effect one word later.
    hold_reset();
    rom[0] = w(8'h00, OP_SKZ); rom[1] = w(8'h40, OP_JMP);
    release_reset("E");
    tick(); push_exp("E bubble", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); run = 1'b0; push_exp("E SKZ", 4'hE, 8'h00, 8'h01, 1, 0, 0);
    tick(); push_exp("E skipJMP", 4'hC, 8'h40, 8'h02, 1, 0, 0);
    tick(); push_exp("E stop",   4'h0, 8'h00, 8'h02, 0, 0, 0);
    tick(); push_exp("E held",   4'h0, 8'h00, 8'h02, 0, 0, 0);

    // Reset during an executing JMP: immediate reset outputs, nothing pushed.
    hold_reset();
    rom[0] = w(8'h20, OP_JMP);
    release_reset("F");
    tick(); push_exp("F bubble", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); rst_n = 1'b0; run = 1'b0;
    push_exp("F rst midJMP", 4'h0, 8'h00, 8'h00, 0, 0, 0);
    tick(); push_exp("F rst hold", 4'h0, 8'h00, 8'h00, 0, 0, 0);
    rom[0] = w(8'h00, OP_RTN);
    tick(); rst_n = 1'b1; run = 1'b1;
    push_exp("F release", 4'h0, 8'h00, 8'h00, 0, 0, 0);
    tick(); push_exp("F bubble2", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); push_exp("F RTN",     4'hD, 8'h00, 8'h01, 1, 0, 0);
    tick(); push_exp("F unf",     4'h0, 8'h00, 8'h00, 1, 0, 1);

    // PC wraps 0xFF -> 0x00.
    hold_reset();
    rom[0] = w(8'hFE, OP_JMP); rom[8'hFE] = w(8'h12, OP_LD);
    rom[8'hFF] = w(8'h34, OP_AND);
    release_reset("G");
    tick(); push_exp("G bubble", 4'h0, 8'h00, 8'h00, 1, 0, 0);
    tick(); push_exp("G JMP",    4'hC, 8'hFE, 8'h01, 1, 0, 0);
    tick(); push_exp("G bub",    4'h0, 8'h00, 8'hFE, 1, 0, 0);
    tick(); push_exp("G FE",     4'h1, 8'h12, 8'hFF, 1, 0, 0);
    tick(); push_exp("G FF",     4'h3, 8'h34, 8'h00, 1, 0, 0);
    tick(); push_exp("G wrap",   4'hC, 8'hFE, 8'h01, 1, 0, 0);

    tick();
    tick();
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
